de0_nano_qsys_led_blink: RTL and testbench

DE0_NANO_QSYS_LED_BLINK -- requirements
Module: de0_nano_qsys_led_blink

---
 rtl/de0_nano_qsys_led_blink.sv | 143 ++++++++++++++
 tb/tb_de0_nano_qsys_led_blink.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/de0_nano_qsys_led_blink.sv
// de0_nano_qsys_led_blink
// Avalon-MM LED blinker. DATA drives the LEDs, and BLINK_MASK selects which
// bits follow a slow phase signal. The phase inverts every
// (PRESCALE+1)*(PERIOD+1) clocks.
// Optional feature macro: LED_BLINK_IRQ_EN adds a toggle flag and an IRQ mask
// (STATUS bit1, address 7) and drives irq. Without it, irq is tied low.

module de0_nano_qsys_led_blink (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  out_port,
  output logic        irq
);

  localparam logic [15:0] PERIOD_RST   = 16'h01F3;
  localparam logic [15:0] PRESCALE_RST = 16'hC34F;

  logic [7:0]  r_data;
  logic [7:0]  r_blink_mask;
  logic [15:0] r_period;
  logic [15:0] r_prescale;
  logic [15:0] r_pre_cnt;
  logic [15:0] r_per_cnt;
  logic        r_phase;

  logic        w_wr;
  logic        w_cfg_wr;
  logic        w_tick;
  logic        w_wrap;
  logic        w_flag;
  logic        w_irq_mask;
  logic [31:0] w_rd_mux;
  logic        w_unused;

  assign w_wr     = chipselect & ~write_n;
  assign w_cfg_wr = w_wr & ((address == 3'd2) | (address == 3'd3));
  assign w_tick   = (r_pre_cnt == r_prescale);
  assign w_wrap   = w_tick & (r_per_cnt == r_period);
  assign w_unused = ^writedata[31:16];

  // Register file writes; OUTSET/OUTCLR modify DATA in place
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data       <= 8'h00;
      r_blink_mask <= 8'h00;
      r_period     <= PERIOD_RST;
      r_prescale   <= PRESCALE_RST;
    end else if (w_wr) begin
      case (address)
        3'd0: r_data       <= writedata[7:0];
        3'd1: r_blink_mask <= writedata[7:0];
        3'd2: r_period     <= writedata[15:0];
        3'd3: r_prescale   <= writedata[15:0];
        3'd4: r_data       <= r_data | writedata[7:0];
        3'd5: r_data       <= r_data & ~writedata[7:0];
        default: ;
      endcase
    end
  end

  // Prescale and period counters; a timing reconfiguration restarts from phase 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre_cnt <= 16'h0000;
      r_per_cnt <= 16'h0000;
      r_phase   <= 1'b0;
    end else if (w_cfg_wr) begin
      r_pre_cnt <= 16'h0000;
      r_per_cnt <= 16'h0000;
      r_phase   <= 1'b0;
    end else if (w_tick) begin
      r_pre_cnt <= 16'h0000;
      if (w_wrap) begin
        r_per_cnt <= 16'h0000;
        r_phase   <= ~r_phase;
      end else begin
        r_per_cnt <= r_per_cnt + 16'h0001;
      end
    end else begin
      r_pre_cnt <= r_pre_cnt + 16'h0001;
    end
  end

`ifdef LED_BLINK_IRQ_EN
  logic r_toggle_flag;
  logic r_irq_mask;

  // Toggle flag sets on each phase inversion; a STATUS write clears it and wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_toggle_flag <= 1'b0;
      r_irq_mask    <= 1'b0;
    end else begin
      if (w_wr && (address == 3'd6)) begin
        r_toggle_flag <= 1'b0;
      end else if (w_wrap && !w_cfg_wr) begin
        r_toggle_flag <= 1'b1;
      end
      if (w_wr && (address == 3'd7)) begin
        r_irq_mask <= writedata[0];
      end
    end
  end

  assign w_flag     = r_toggle_flag;
  assign w_irq_mask = r_irq_mask;
`else
  assign w_flag     = 1'b0;
  assign w_irq_mask = 1'b0;
`endif

  // Read mux for the presented address; write-only and unused bits read 0
  always_comb begin
    w_rd_mux = 32'h0000_0000;
    case (address)
      3'd0: w_rd_mux[7:0]  = r_data;
      3'd1: w_rd_mux[7:0]  = r_blink_mask;
      3'd2: w_rd_mux[15:0] = r_period;
      3'd3: w_rd_mux[15:0] = r_prescale;
      3'd6: w_rd_mux[1:0]  = {w_flag, r_phase};
      3'd7: w_rd_mux[0]    = w_irq_mask;
      default: w_rd_mux = 32'h0000_0000;
    endcase
  end

  // Read data is registered every clock regardless of chipselect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 32'h0000_0000;
    end else begin
      readdata <= w_rd_mux;
    end
  end

  assign out_port = (r_data & ~r_blink_mask) | (r_data & r_blink_mask & {8{r_phase}});
  assign irq      = w_flag & w_irq_mask;

endmodule

// File: tb/tb_de0_nano_qsys_led_blink.sv
// Testbench for de0_nano_qsys_led_blink: elapsed-cycle reference model plus
// directed register/blink sequences with literal expectations.

module tb_de0_nano_qsys_led_blink;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;
  bit checking = 0;

  de0_nano_qsys_led_blink dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase derives from edges elapsed since the last clear
  logic [7:0]  m_data, m_mask;
  logic [15:0] m_period, m_prescale;
  longint      m_c, m_len;
  logic        m_phase, m_flag, m_irqmask, m_wr, m_tog;
  logic [31:0] m_rd;

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [31:0] v;
    v = 32'h0;
    case (a)
      3'd0: v = {24'h0, m_data};
      3'd1: v = {24'h0, m_mask};
      3'd2: v = {16'h0, m_period};
      3'd3: v = {16'h0, m_prescale};
      3'd6: v = {30'h0, m_flag, m_phase};
      3'd7: v = {31'h0, m_irqmask};
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data = 8'h00; m_mask = 8'h00;
      m_period = 16'h01F3; m_prescale = 16'hC34F;
      m_c = 0; m_phase = 1'b0; m_flag = 1'b0; m_irqmask = 1'b0;
      m_rd = 32'h0;
    end else begin
      m_rd  = model_read(address);
      m_wr  = chipselect && !write_n;
      m_tog = 1'b0;
      if (m_wr && (address == 3'd2 || address == 3'd3)) begin
        if (address == 3'd2) m_period = writedata[15:0];
        else                 m_prescale = writedata[15:0];
        m_c = 0;
        m_phase = 1'b0;
      end else begin
        m_len = (longint'(m_prescale) + 1) * (longint'(m_period) + 1);
        m_c++;
        m_tog = ((m_c % m_len) == 0);
        m_phase = ((m_c / m_len) % 2) == 1;
      end
      if (m_wr) begin
        case (address)
          3'd0: m_data = writedata[7:0];
          3'd1: m_mask = writedata[7:0];
          3'd4: m_data = m_data | writedata[7:0];
          3'd5: m_data = m_data & ~writedata[7:0];
          default: ;
        endcase
      end
`ifdef LED_BLINK_IRQ_EN
      if (m_tog) m_flag = 1'b1;
      if (m_wr && address == 3'd6) m_flag = 1'b0;
      if (m_wr && address == 3'd7) m_irqmask = writedata[0];
`endif
    end
  end

  // Compare DUT against the model away from the active edge
  always @(negedge clk) begin
    if (checking) begin
      chk("model_readdata", readdata, m_rd);
      chk("model_out_port", {24'h0, out_port},
          {24'h0, (m_data & ~m_mask) | (m_data & m_mask & {8{m_phase}})});
      chk("model_irq", {31'h0, irq}, {31'h0, m_flag & m_irqmask});
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0; address = 3'd6;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    address = a;
    @(negedge clk);
    chk(name, readdata, exp);
    address = 3'd6;
  endtask

  logic [31:0] rst_tbl [8];

  initial begin
    rst_tbl = '{32'h0, 32'h0, 32'h01F3, 32'hC34F, 32'h0, 32'h0, 32'h0, 32'h0};
    reset_n = 1'b0; address = 3'd6; chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_out_port", {24'h0, out_port}, 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);
    chk("reset_readdata", readdata, 32'h0);
    reset_n = 1'b1;
    checking = 1'b1;
    @(negedge clk);

    // Reset values of every address
    for (int a = 0; a < 8; a++) rd(3'(a), rst_tbl[a], "reset_read");

    // DATA, OUTSET, OUTCLR
    wr(3'd0, 32'hA5); chk("data_write", {24'h0, out_port}, 32'hA5);
    wr(3'd4, 32'h0A); chk("outset", {24'h0, out_port}, 32'hAF);
    wr(3'd5, 32'h81); chk("outclr", {24'h0, out_port}, 32'h2E);

    // Upper bits ignored, STATUS bit0 not writable, address 7
    wr(3'd0, 32'hFFFF_FF3C); rd(3'd0, 32'h3C, "data_width");
    wr(3'd2, 32'hABCD_0007); rd(3'd2, 32'h7, "period_width");
    wr(3'd6, 32'h1);         rd(3'd6, 32'h0, "status_ro");
    wr(3'd7, 32'hFFFF_FFFF);
`ifdef LED_BLINK_IRQ_EN
    rd(3'd7, 32'h1, "irq_mask_rw");
`else
    rd(3'd7, 32'h0, "irq_mask_absent");
`endif
    wr(3'd7, 32'h0);

    // Blink: PRESCALE=0, PERIOD=3 -> 4 cycles 0xF0, 4 cycles 0xFF
    wr(3'd0, 32'hFF); wr(3'd1, 32'h0F);
    wr(3'd3, 32'h0);  wr(3'd2, 32'h3);
    for (int i = 0; i < 12; i++) begin
      chk("blink_p3", {24'h0, out_port}, ((i / 4) % 2) ? 32'hFF : 32'hF0);
      @(negedge clk);
    end

    // PRESCALE=2, PERIOD=1; rewrite PERIOD mid-interval
    wr(3'd1, 32'hFF);
    wr(3'd3, 32'h2); wr(3'd2, 32'h1);
    repeat (7) @(negedge clk);
    chk("pre2_first_toggle", {24'h0, out_port}, 32'hFF);
    wr(3'd2, 32'h1);
    chk("rewrite_phase0", {24'h0, out_port}, 32'h00);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("rewrite_toggle", {24'h0, out_port}, (i < 6) ? 32'h00 : 32'hFF);
    end
    // DATA/MASK writes must not disturb the running interval
    wr(3'd0, 32'hFF); wr(3'd1, 32'hFF);
    repeat (5) @(negedge clk);

`ifdef LED_BLINK_IRQ_EN
    wr(3'd2, 32'hFFFF); wr(3'd6, 32'h0); wr(3'd7, 32'h1);
    wr(3'd3, 32'h0);
    chk("irq_idle", {31'h0, irq}, 32'h0);
    wr(3'd2, 32'h0);
    chk("irq_after_cfg", {31'h0, irq}, 32'h0);
    @(negedge clk);
    chk("irq_first_toggle", {31'h0, irq}, 32'h1);
    wr(3'd6, 32'h0);
    chk("irq_clear_wins", {31'h0, irq}, 32'h0);
    @(negedge clk);
    chk("irq_next_toggle", {31'h0, irq}, 32'h1);
    wr(3'd7, 32'h0);
`endif

    // Asynchronous reset between clock edges
    wr(3'd2, 32'hFFFF); wr(3'd1, 32'h00); wr(3'd0, 32'hFF);
    chk("pre_reset_out", {24'h0, out_port}, 32'hFF);
    #3 reset_n = 1'b0;
    #1;
    chk("async_reset_out", {24'h0, out_port}, 32'h00);
    chk("async_reset_irq", {31'h0, irq}, 32'h0);
    chk("async_reset_rd", readdata, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd(3'd3, 32'hC34F, "post_reset_prescale");
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
